// File: rtl/rv32_mem_pkg.sv
// rtl/rv32_mem_pkg.sv - FUNCT3 width codes and FSM states shared by the data-memory blocks
package rv32_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - load extraction/extension and store byte-enable/replication
module dmem_lane_align
  import rv32_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data,
  output logic [3:0]  byte_en
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte   = rdata[8*lane +: 8];
    sel_half   = lane[1] ? rdata[31:16] : rdata[15:0];
    load_data  = rdata;
    store_data = wdata;
    byte_en    = 4'b1111;
    case (funct3)
      F3_B: begin
        load_data  = {{24{sel_byte[7]}}, sel_byte};
        store_data = {4{wdata[7:0]}};
        byte_en    = 4'b0001 << lane;
      end
      F3_BU: begin
        load_data  = {24'h0, sel_byte};
        store_data = {4{wdata[7:0]}};
        byte_en    = 4'b0001 << lane;
      end
      F3_H: begin
        load_data  = {{16{sel_half[15]}}, sel_half};
        store_data = {2{wdata[15:0]}};
        byte_en    = lane[1] ? 4'b1100 : 4'b0011;
      end
      F3_HU: begin
        load_data  = {16'h0, sel_half};
        store_data = {2{wdata[15:0]}};
        byte_en    = lane[1] ? 4'b1100 : 4'b0011;
      end
      // F3_W and every unlisted code behave as a full word
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_controller.sv
// rtl/data_memory_controller.sv - fixed-latency RV32 data memory with BUSYWAIT stall
// Define DMEM_MISALIGN_CHECK_EN to flag (and suppress) misaligned H/W accesses instead of truncating.
module data_memory_controller
  import rv32_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSYWAIT,
  output logic        MISALIGNED
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  mem_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            load_q, load_d;
  logic            store_q, store_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     read_data_q, read_data_d;
  logic            misaligned_q, misaligned_d;

  logic [31:0]     mem [DEPTH_WORDS];
  logic [AW-1:0]   word_idx;
  logic [31:0]     load_data;
  logic [31:0]     store_data;
  logic [3:0]      byte_en;
  logic            do_access;
  logic            mis_acc;
  logic            mem_we;
  logic            unused_addr_hi;

  // Word index wraps: address bits above the array are simply dropped
  assign unused_addr_hi = ^ADDRESS[31:AW+2];
  assign word_idx       = addr_q[AW+1:2];

  dmem_lane_align u_align (
    .funct3     (funct3_q),
    .lane       (addr_q[1:0]),
    .rdata      (mem[word_idx]),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (store_data),
    .byte_en    (byte_en)
  );

`ifdef DMEM_MISALIGN_CHECK_EN
  logic is_byte, is_half;
  assign is_byte = (funct3_q == F3_B) || (funct3_q == F3_BU);
  assign is_half = (funct3_q == F3_H) || (funct3_q == F3_HU);
  assign mis_acc = (is_half && addr_q[0]) || (!is_byte && !is_half && (addr_q[1:0] != 2'b00));
`else
  assign mis_acc = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    load_d       = load_q;
    store_d      = store_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    read_data_d  = read_data_q;
    misaligned_d = 1'b0;
    do_access    = 1'b0;
    BUSYWAIT     = 1'b0;
    case (state_q)
      IDLE: begin
        if (MEM_READ || MEM_WRITE) begin
          BUSYWAIT = 1'b1;
          state_d  = ACCESS;
          cnt_d    = CW'(LATENCY - 1);
          // A combined read+write is a plain store
          load_d   = MEM_READ && !MEM_WRITE;
          store_d  = MEM_WRITE;
          funct3_d = FUNCT3;
          addr_d   = ADDRESS[AW+1:0];
          wdata_d  = WRITE_DATA;
        end
      end
      ACCESS: begin
        BUSYWAIT = 1'b1;
        if (cnt_q == '0) begin
          do_access    = 1'b1;
          state_d      = DONE;
          misaligned_d = mis_acc;
          if (load_q) read_data_d = mis_acc ? 32'h0 : load_data;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_we     = do_access && store_q && !mis_acc;
  assign READ_DATA  = read_data_q;
  assign MISALIGNED = misaligned_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      load_q       <= 1'b0;
      store_q      <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      read_data_q  <= 32'h0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      load_q       <= load_d;
      store_q      <= store_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      read_data_q  <= read_data_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Storage is never cleared; writes are gated by the FSM, which reset forces to IDLE
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= store_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_controller.sv
// tb/tb_data_memory_controller.sv - directed and randomized checks of data_memory_controller
module tb_data_memory_controller;

  localparam int LAT = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        MEM_READ = 1'b0;
  logic        MEM_WRITE = 1'b0;
  logic [2:0]  FUNCT3 = 3'b000;
  logic [31:0] ADDRESS = 32'h0;
  logic [31:0] WRITE_DATA = 32'h0;
  logic [31:0] READ_DATA;
  logic        BUSYWAIT;
  logic        MISALIGNED;

  int total = 0;
  int bad = 0;

  logic [31:0] mem_m [256];
  logic [31:0] exp_rd = 32'h0;

  data_memory_controller dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .MEM_READ   (MEM_READ),
    .MEM_WRITE  (MEM_WRITE),
    .FUNCT3     (FUNCT3),
    .ADDRESS    (ADDRESS),
    .WRITE_DATA (WRITE_DATA),
    .READ_DATA  (READ_DATA),
    .BUSYWAIT   (BUSYWAIT),
    .MISALIGNED (MISALIGNED)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int unsigned w = mem_m[a[9:2]];
    int v;
    case (f3)
      3'b000: begin v = int'((w >> (8 * a[1:0])) & 32'hFF);   if (v >= 128)   v -= 256;   end
      3'b100:       v = int'((w >> (8 * a[1:0])) & 32'hFF);
      3'b001: begin v = int'((w >> (16 * a[1])) & 32'hFFFF);  if (v >= 32768) v -= 65536; end
      3'b101:       v = int'((w >> (16 * a[1])) & 32'hFFFF);
      default:      v = int'(w);
    endcase
    return 32'(v);
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int size;
    int off;
    logic [31:0] mask;
    case (f3)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      default:        size = 4;
    endcase
    off  = (size == 4) ? 0 : (size == 2) ? 2 * int'(a[1]) : int'(a[1:0]);
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    mem_m[a[9:2]] = (mem_m[a[9:2]] & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that leaves DONE
  task automatic mem_op(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input string tag);
    int busy = 0;
    bit done = 0;
    MEM_READ = rd; MEM_WRITE = wr; FUNCT3 = f3; ADDRESS = a; WRITE_DATA = wd;
    if (wr) model_store(f3, a, wd);
    else if (rd) exp_rd = model_load(f3, a);
    for (int i = 0; i < 3 * LAT + 8 && !done; i++) begin
      @(negedge CLK);
      if (BUSYWAIT) begin
        busy++;
        @(posedge CLK);
        #1;
      end else begin
        done = 1;
      end
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy_cycles"}, 32'(busy), 32'(LAT + 1));
    check({tag, " read_data"}, READ_DATA, exp_rd);
    check({tag, " misaligned"}, 32'(MISALIGNED), 32'd0);
    @(posedge CLK);
    #1;
    MEM_READ = 1'b0; MEM_WRITE = 1'b0;
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    bit          rd, wr;

    repeat (2) @(negedge CLK);
    check("reset busywait", 32'(BUSYWAIT), 32'd0);
    check("reset read_data", READ_DATA, 32'h0);
    check("reset misaligned", 32'(MISALIGNED), 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    check("idle busywait", 32'(BUSYWAIT), 32'd0);
    @(posedge CLK);
    #1;

    foreach (mem_m[i]) mem_m[i] = 32'h0;
    for (int w = 4; w <= 20; w += 4) mem_op(0, 1, 3'b010, 32'(w * 4), 32'h0, "clear");
    for (int w = 64; w < 80; w++) mem_op(0, 1, 3'b010, 32'(w * 4), 32'h0, "clear");

    mem_op(0, 1, 3'b010, 32'h10, 32'hDEAD_BEEF, "sw 10");
    mem_op(1, 0, 3'b010, 32'h10, 32'h0, "lw 10");
    check("lw 10 literal", READ_DATA, 32'hDEAD_BEEF);
    mem_op(1, 0, 3'b010, 32'hFFFF_F010, 32'h0, "lw wrap");
    mem_op(1, 0, 3'b010, 32'h13, 32'h0, "lw 13 trunc");
    check("lw 13 literal", READ_DATA, 32'hDEAD_BEEF);

    mem_op(0, 1, 3'b000, 32'h21, 32'h0000_0080, "sb 21");
    mem_op(1, 0, 3'b000, 32'h21, 32'h0, "lb 21");
    check("lb 21 literal", READ_DATA, 32'hFFFF_FF80);
    mem_op(1, 0, 3'b100, 32'h21, 32'h0, "lbu 21");
    check("lbu 21 literal", READ_DATA, 32'h0000_0080);
    mem_op(1, 0, 3'b010, 32'h20, 32'h0, "lw 20");
    check("lw 20 literal", READ_DATA, 32'h0000_8000);

    mem_op(0, 1, 3'b001, 32'h32, 32'h1234_8001, "sh 32");
    mem_op(1, 0, 3'b001, 32'h32, 32'h0, "lh 32");
    check("lh 32 literal", READ_DATA, 32'hFFFF_8001);
    mem_op(1, 0, 3'b101, 32'h32, 32'h0, "lhu 32");
    check("lhu 32 literal", READ_DATA, 32'h0000_8001);
    mem_op(1, 0, 3'b001, 32'h30, 32'h0, "lh 30");
    check("lh 30 literal", READ_DATA, 32'h0);
    mem_op(1, 0, 3'b001, 32'h33, 32'h0, "lh 33 trunc");

    // Reset pulse while a store is in ACCESS
    MEM_WRITE = 1'b1; FUNCT3 = 3'b010; ADDRESS = 32'h40; WRITE_DATA = 32'h1234_5678;
    @(posedge CLK);
    @(posedge CLK);
    #3;
    RESET = 1'b1; MEM_WRITE = 1'b0;
    #1;
    check("abort busywait", 32'(BUSYWAIT), 32'd0);
    check("abort read_data", READ_DATA, 32'h0);
    exp_rd = 32'h0;
    @(negedge CLK);
    check("abort busywait held", 32'(BUSYWAIT), 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    mem_op(1, 0, 3'b010, 32'h40, 32'h0, "lw 40 after abort");
    check("lw 40 literal", READ_DATA, 32'h0);

    mem_op(1, 0, 3'b010, 32'h10, 32'h0, "lw 10 again");
    mem_op(1, 1, 3'b010, 32'h50, 32'h0000_00AA, "rd+wr 50");
    check("rd+wr keeps read_data", READ_DATA, 32'hDEAD_BEEF);
    mem_op(1, 0, 3'b010, 32'h50, 32'h0, "lw 50");
    check("lw 50 literal", READ_DATA, 32'h0000_00AA);

    for (int n = 0; n < 60; n++) begin
      rd = 1'($urandom);
      wr = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom & 32'hFFFF_FC00) | 32'h100 | 32'($urandom_range(0, 63));
      mem_op(rd, wr, f3, a, $urandom, $sformatf("rand%0d", n));
    end

    for (int w = 64; w < 80; w++) mem_op(1, 0, 3'b010, 32'(w * 4), 32'h0, "final lw");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
